// File: rtl/flash_pack_pkg.sv
// flash_pack_pkg
//   Shared types and constants for the flash word packer:
//   - fp_state_e      : packer state (RUN, FLUSH)
//   - FP_MAX_WORD_BYTES : widest supported output word in bytes
//   - FP_CNT_W        : width of the accumulator fill counter
//   - FP_CSUM_W       : width of the running checksum
//   - fp_keep_mask()  : byte-enable mask with the low n bits set
package flash_pack_pkg;

  typedef enum logic [0:0] {
    FP_RUN   = 1'b0,
    FP_FLUSH = 1'b1
  } fp_state_e;

  localparam int FP_MAX_WORD_BYTES = 4;
  // Fill count must reach WORD_BYTES itself (a full, blocked accumulator).
  localparam int FP_CNT_W          = $clog2(FP_MAX_WORD_BYTES + 1);
  localparam int FP_CSUM_W         = 32;

  // Keep mask for a word holding n valid bytes in arrival order.
  function automatic logic [FP_MAX_WORD_BYTES-1:0] fp_keep_mask(input logic [FP_CNT_W-1:0] n);
    logic [FP_MAX_WORD_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < FP_MAX_WORD_BYTES; i++) begin
      if (FP_CNT_W'(i) < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/flash_pack_csum.sv
// flash_pack_csum
//   Additive 32-bit checksum of captured bytes, wrapping modulo 2^32.
//   Ports:
//     system_clk, system_reset_n : clock, async active-low reset
//     clr_i  : start a new sum; combined with en_i the sum restarts at byte_i
//     en_i   : add byte_i this cycle
//     byte_i : captured byte
//     sum_o  : registered running sum
module flash_pack_csum
  import flash_pack_pkg::*;
(
  input  logic                 system_clk,
  input  logic                 system_reset_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [7:0]           byte_i,
  output logic [FP_CSUM_W-1:0] sum_o
);

  logic [FP_CSUM_W-1:0] sum_q;
  logic [FP_CSUM_W-1:0] sum_d;
  logic [FP_CSUM_W-1:0] base_s;

  // Next sum: optionally restart from zero, then add the new byte.
  always_comb begin
    if (clr_i) begin
      base_s = '0;
    end else begin
      base_s = sum_q;
    end
    if (en_i) begin
      sum_d = base_s + {{(FP_CSUM_W-8){1'b0}}, byte_i};
    end else begin
      sum_d = base_s;
    end
  end

  // Sum register.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/flash_word_packer.sv
// flash_word_packer
//   Pops bytes from the spi_flash_read byte FIFO, packs them into
//   WORD_BYTES-wide words and presents them on a valid/ready stream with
//   byte keep and last markers. A read_finish pulse produces a final
//   partial word (or a zero-keep terminator when word aligned) once every
//   byte already in the FIFO has been packed.
//
//   Parameters:
//     WORD_BYTES : 2 or 4 bytes per output word
//     MSB_FIRST  : 0 = first byte in bits [7:0], 1 = first byte in top byte
//   Ports:
//     system_clk, system_reset_n : clock, async active-low reset
//     fifo_empty, fifo_data      : FIFO read side (data valid cycle after pop)
//     fifo_read_req              : FIFO pop strobe (combinational)
//     read_finish                : end-of-transfer pulse from the reader
//     word_data/keep/last/valid  : output word stream, word_ready accepts
//     byte_count                 : bytes captured in the current transfer
//     checksum                   : running byte sum
//
//   Build option: define FLASH_PACK_CSUM_EN to include the checksum
//   accumulator; without it the checksum port reads 32'h0.
module flash_word_packer
  import flash_pack_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                    system_clk,
  input  logic                    system_reset_n,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_data,
  output logic                    fifo_read_req,
  input  logic                    read_finish,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic [WORD_BYTES-1:0]   word_keep,
  output logic                    word_last,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [31:0]             byte_count,
  output logic [31:0]             checksum
);

  localparam logic [FP_CNT_W-1:0] WB_C = FP_CNT_W'(WORD_BYTES);

  fp_state_e                       state_q, state_d;
  logic [WORD_BYTES-1:0][7:0]      acc_q, acc_d;
  logic [FP_CNT_W-1:0]             acc_cnt_q, acc_cnt_d;
  logic                            inflight_q;
  logic                            finish_pend_q, finish_pend_d;
  // Set by a completed flush: the next capture starts a new transfer.
  logic                            restart_q, restart_d;
  logic [8*WORD_BYTES-1:0]         word_data_q, word_data_d;
  logic [WORD_BYTES-1:0]           word_keep_q, word_keep_d;
  logic                            word_last_q, word_last_d;
  logic                            word_valid_q, word_valid_d;
  logic [31:0]                     byte_count_q, byte_count_d;

  logic                            capture_s;
  logic                            out_free_s;
  logic                            flush_go_s;
  logic                            pop_s;
  logic                            load_s;
  logic [FP_CNT_W-1:0]             fill_cnt_s;
  logic [FP_MAX_WORD_BYTES-1:0]    flush_keep_full_s;
  logic [31:0]                     checksum_s;

  // Place the first n accumulator bytes in arrival order; unused bytes are 0.
  function automatic logic [8*WORD_BYTES-1:0] pack_word(input logic [WORD_BYTES-1:0][7:0] src,
                                                        input logic [FP_CNT_W-1:0] n);
    logic [8*WORD_BYTES-1:0] w;
    logic [7:0]              b;
    w = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (FP_CNT_W'(i) < n) begin
        b = src[i];
      end else begin
        b = 8'h00;
      end
      if (MSB_FIRST) begin
        w[8*(WORD_BYTES-1-i) +: 8] = b;
      end else begin
        w[8*i +: 8] = b;
      end
    end
    return w;
  endfunction

  // Pop control and handshake qualifiers.
  always_comb begin
    capture_s  = inflight_q;
    out_free_s = !word_valid_q || word_ready;
    fill_cnt_s = acc_cnt_q + {{(FP_CNT_W-1){1'b0}}, capture_s};
    flush_go_s = (state_q == FP_RUN) && finish_pend_q && fifo_empty &&
                 !inflight_q && (acc_cnt_q < WB_C);
    // A byte in flight reserves its slot, so a full word never over-pops.
    pop_s      = !fifo_empty && (state_q == FP_RUN) && !flush_go_s &&
                 ((acc_cnt_q + {{(FP_CNT_W-1){1'b0}}, inflight_q}) < WB_C);
  end

  assign flush_keep_full_s = fp_keep_mask(acc_cnt_q);

  // Capture, word completion, flush and output register next state.
  always_comb begin
    acc_d         = acc_q;
    acc_cnt_d     = acc_cnt_q;
    state_d       = state_q;
    finish_pend_d = finish_pend_q | read_finish;
    restart_d     = restart_q;
    byte_count_d  = byte_count_q;
    word_data_d   = word_data_q;
    word_keep_d   = word_keep_q;
    word_last_d   = word_last_q;
    load_s        = 1'b0;

    if (capture_s) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (acc_cnt_q == FP_CNT_W'(i)) begin
          acc_d[i] = fifo_data;
        end else begin
          acc_d[i] = acc_q[i];
        end
      end
      if (restart_q) begin
        byte_count_d = 32'd1;
      end else begin
        byte_count_d = byte_count_q + 32'd1;
      end
      restart_d = 1'b0;
      acc_cnt_d = fill_cnt_s;
    end else begin
      byte_count_d = byte_count_q;
    end

    // A full accumulator (just filled, or held full by back-pressure) moves out.
    if ((fill_cnt_s == WB_C) && out_free_s) begin
      load_s      = 1'b1;
      word_data_d = pack_word(acc_d, WB_C);
      word_keep_d = '1;
      word_last_d = 1'b0;
      acc_cnt_d   = '0;
    end else if ((state_q == FP_FLUSH) && out_free_s) begin
      load_s        = 1'b1;
      word_data_d   = pack_word(acc_q, acc_cnt_q);
      word_keep_d   = flush_keep_full_s[WORD_BYTES-1:0];
      word_last_d   = 1'b1;
      acc_cnt_d     = '0;
      finish_pend_d = 1'b0;
      restart_d     = 1'b1;
      state_d       = FP_RUN;
    end else if (flush_go_s) begin
      state_d = FP_FLUSH;
    end else begin
      state_d = state_q;
    end

    if (load_s) begin
      word_valid_d = 1'b1;
    end else if (word_ready) begin
      word_valid_d = 1'b0;
    end else begin
      word_valid_d = word_valid_q;
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q       <= FP_RUN;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      finish_pend_q <= 1'b0;
      restart_q     <= 1'b0;
      byte_count_q  <= 32'h0;
      word_data_q   <= '0;
      word_keep_q   <= '0;
      word_last_q   <= 1'b0;
      word_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      acc_cnt_q     <= acc_cnt_d;
      inflight_q    <= pop_s;
      finish_pend_q <= finish_pend_d;
      restart_q     <= restart_d;
      byte_count_q  <= byte_count_d;
      word_data_q   <= word_data_d;
      word_keep_q   <= word_keep_d;
      word_last_q   <= word_last_d;
      word_valid_q  <= word_valid_d;
    end
  end

`ifdef FLASH_PACK_CSUM_EN
  flash_pack_csum u_csum (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .clr_i          (capture_s && restart_q),
    .en_i           (capture_s),
    .byte_i         (fifo_data),
    .sum_o          (checksum_s)
  );
`else
  assign checksum_s = 32'h0;
`endif

  assign fifo_read_req = pop_s;
  assign word_data     = word_data_q;
  assign word_keep     = word_keep_q;
  assign word_last     = word_last_q;
  assign word_valid    = word_valid_q;
  assign byte_count    = byte_count_q;
  assign checksum      = checksum_s;

endmodule

// File: tb/tb_flash_word_packer.sv
// Self-checking bench for flash_word_packer (WORD_BYTES=4, MSB_FIRST=0).
// A byte-FIFO model feeds the DUT; each byte pushed also feeds a packing
// model whose expected words go to a scoreboard queue, popped as the DUT
// hands words over.
module tb_flash_word_packer;

  logic        system_clk;
  logic        system_reset_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read_req;
  logic        read_finish;
  logic [31:0] word_data;
  logic [3:0]  word_keep;
  logic        word_last;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] byte_count;
  logic [31:0] checksum;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_word_t;

  exp_word_t   exp_q[$];
  logic [7:0]  fq[$];

  int          n_checks;
  int          n_fail;
  int          pops;

  // Packing model state.
  logic [31:0] m_word;
  int          m_cnt;
  logic [31:0] m_bc;
  logic [31:0] m_cs;
  logic        m_restart;

`ifdef FLASH_PACK_CSUM_EN
  localparam logic [31:0] CSUM_FF4 = 32'h0000_03FC;
  localparam bit          CSUM_ON  = 1'b1;
`else
  localparam logic [31:0] CSUM_FF4 = 32'h0000_0000;
  localparam bit          CSUM_ON  = 1'b0;
`endif

  flash_word_packer #(.WORD_BYTES(4), .MSB_FIRST(1'b0)) dut (
    .system_clk     (system_clk),
    .system_reset_n (system_reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_read_req  (fifo_read_req),
    .read_finish    (read_finish),
    .word_data      (word_data),
    .word_keep      (word_keep),
    .word_last      (word_last),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then model the FIFO just after posedge.
  task automatic tick();
    logic      req_smp;
    exp_word_t e;
    @(negedge system_clk);
    req_smp = fifo_read_req;
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", {32'h0, word_data}, 64'h0 - 64'h1);
      end else begin
        e = exp_q.pop_front();
        check_eq("word_data", {32'h0, word_data}, {32'h0, e.data});
        check_eq("word_keep", {60'h0, word_keep}, {60'h0, e.keep});
        check_eq("word_last", {63'h0, word_last}, {63'h0, e.last});
      end
    end
    @(posedge system_clk);
    #1;
    read_finish = 1'b0;
    if (req_smp) begin
      if (fq.size() == 0) begin
        check_eq("pop_on_empty", 64'h1, 64'h0);
      end else begin
        fifo_data = fq.pop_front();
        pops++;
      end
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
    if (m_restart) begin
      m_bc      = 32'd1;
      m_cs      = {24'h0, b};
      m_restart = 1'b0;
    end else begin
      m_bc = m_bc + 32'd1;
      m_cs = m_cs + {24'h0, b};
    end
    m_word[8*m_cnt +: 8] = b;
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back('{data: m_word, keep: 4'hF, last: 1'b0});
      m_cnt  = 0;
      m_word = 32'h0;
    end
  endtask

  task automatic send_finish();
    logic [3:0] k;
    read_finish = 1'b1;
    k = 4'((1 << m_cnt) - 1);
    exp_q.push_back('{data: m_word, keep: k, last: 1'b1});
    m_cnt     = 0;
    m_word    = 32'h0;
    m_restart = 1'b1;
  endtask

  task automatic model_reset();
    m_word    = 32'h0;
    m_cnt     = 0;
    m_bc      = 32'h0;
    m_cs      = 32'h0;
    m_restart = 1'b0;
    exp_q.delete();
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  // Run until every queued byte and expected word is consumed, bounded.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(exp_q.size() + fq.size()), 64'h0);
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_valid"}, {63'h0, word_valid}, 64'h0);
    check_eq({pfx, "_data"},  {32'h0, word_data},  64'h0);
    check_eq({pfx, "_keep"},  {60'h0, word_keep},  64'h0);
    check_eq({pfx, "_last"},  {63'h0, word_last},  64'h0);
    check_eq({pfx, "_bcnt"},  {32'h0, byte_count}, 64'h0);
    check_eq({pfx, "_csum"},  {32'h0, checksum},   64'h0);
    check_eq({pfx, "_req"},   {63'h0, fifo_read_req}, 64'h0);
  endtask

  initial begin
    int n;
    n_checks       = 0;
    n_fail         = 0;
    pops           = 0;
    system_reset_n = 1'b0;
    fifo_data      = 8'h00;
    read_finish    = 1'b0;
    word_ready     = 1'b1;
    model_reset();

    repeat (3) tick();
    check_outputs_zero("reset");
    system_reset_n = 1'b1;
    tick();

    // Basic packing, then an aligned finish gives a terminator.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    check_eq("basic_model_word", {32'h0, exp_q[0].data}, 64'h4433_2211);
    drain("basic_drain");
    check_eq("basic_bcnt", {32'h0, byte_count}, 64'd4);
    send_finish();
    drain("basic_term_drain");

    // Partial final word; finish raised while bytes are still queued.
    for (int i = 1; i <= 6; i++) push_byte(8'(8'h11 * i));
    send_finish();
    check_eq("partial_model_word", {32'h0, exp_q[1].data}, 64'h0000_6655);
    drain("partial_drain");
    check_eq("partial_bcnt", {32'h0, byte_count}, {32'h0, m_bc});
    check_eq("partial_bcnt_6", {32'h0, byte_count}, 64'd6);

    // Word-aligned finish: two full words and a terminator.
    for (int i = 0; i < 8; i++) push_byte(8'(8'hA0 + i));
    send_finish();
    drain("aligned_drain");
    check_eq("aligned_bcnt", {32'h0, byte_count}, 64'd8);

    // Checksum of four 0xFF bytes.
    repeat (4) push_byte(8'hFF);
    drain("csum_drain");
    check_eq("csum_ff", {32'h0, checksum}, {32'h0, CSUM_FF4});
    check_eq("csum_model", {32'h0, checksum}, CSUM_ON ? {32'h0, m_cs} : 64'h0);
    check_eq("csum_bcnt", {32'h0, byte_count}, 64'd4);
    send_finish();
    drain("csum_term_drain");

    // Back-pressure: 12 bytes queued, output stalled for 30 cycles.
    word_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 12; i++) push_byte(8'($urandom_range(255)));
    repeat (30) tick();
    check_eq("bp_pops", 64'(pops), 64'd8);
    check_eq("bp_req_low", {63'h0, fifo_read_req}, 64'h0);
    check_eq("bp_valid", {63'h0, word_valid}, 64'h1);
    check_eq("bp_stable_data", {32'h0, word_data}, {32'h0, exp_q[0].data});
    word_ready = 1'b1;
    drain("bp_drain");
    check_eq("bp_bcnt", {32'h0, byte_count}, {32'h0, m_bc});
    send_finish();
    drain("bp_term_drain");

    // Reset after two bytes captured.
    push_byte(8'h5A); push_byte(8'hC3);
    n = 0;
    while (byte_count != 32'd2 && n < 50) begin
      tick();
      n++;
    end
    check_eq("mid_bcnt_2", {32'h0, byte_count}, 64'd2);
    system_reset_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    repeat (2) tick();
    system_reset_n = 1'b1;
    tick();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    check_eq("midrst_model_word", {32'h0, exp_q[0].data}, 64'h0403_0201);
    drain("midrst_drain");
    check_eq("midrst_bcnt", {32'h0, byte_count}, 64'd4);
    check_eq("midrst_idle", {63'h0, word_valid}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_word_packer.md
# flash_word_packer

Drains the byte FIFO that `spi_flash_read` fills and assembles flash bytes into output words. Each word goes out on a valid/ready stream with byte-keep and last markers. The block sits directly downstream of the FIFO read port and turns the reader's `read_finish` pulse into a final, correctly marked word. It also keeps a byte counter and, optionally, an additive checksum of the transfer.

## Interface
- `WORD_BYTES`, default 4: bytes per output word; legal values are 2 and 4.
- `MSB_FIRST`, default 0: 0 puts the first byte in bits [7:0] (little-endian); 1 puts the first byte in the top byte.
- `system_clk`  in  1  clock.
- `system_reset_n`  in  1  reset, asynchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO output byte; valid the cycle after `fifo_read_req`.
- `fifo_read_req`  out  1  FIFO pop strobe.
- `read_finish`  in  1  one-cycle pulse; all bytes of the transfer have been written to the FIFO.
- `word_data`  out  8*WORD_BYTES  packed word.
- `word_keep`  out  WORD_BYTES  byte enables; bit i covers byte i in arrival order.
- `word_last`  out  1  final word of the transfer.
- `word_valid`  out  1  output word valid.
- `word_ready`  in  1  consumer accepts.
- `byte_count`  out  32  bytes captured in the current transfer.
- `checksum`  out  32  running byte sum.

## Operation
**Registers**
- Accumulator: `acc`, with fill count `acc_cnt`.
- In-flight flag: `inflight` (pop issued last cycle).
- Output register: `word_*` outputs.
- Sticky `finish_pend`.

**Pop rule**
- `fifo_read_req = !fifo_empty && state==RUN && !finish_pend_blocked && (acc_cnt + inflight < WORD_BYTES)`.
- This rule is combinational.

**Capture (cycle after a pop)**
- `fifo_data` goes into slot `acc_cnt`.
- `byte_count` increments by 1, wrapping mod 2^32.
- `checksum += {24'b0, fifo_data}`, mod 2^32.

**Word completion**
- When a capture fills the last slot, the accumulator moves to the output register on that same edge, provided `!word_valid || word_ready`.
- On a move: keep is all ones, last=0, and `acc_cnt` returns to 0.
- If the output register is blocked, the accumulator stays full and pops stop; the move happens on the first edge where `word_ready`=1.

**Finish handling**
- A `read_finish` pulse sets `finish_pend`. A second pulse while it is pending is ignored.

**State machine**
- RUN → FLUSH when `finish_pend && fifo_empty && !inflight && acc_cnt<WORD_BYTES`.
- In FLUSH, once the output register is free:
  - if `acc_cnt`>0: load the partial word. Unused bytes are 0, keep has the low `acc_cnt` bits set, last=1.
  - if `acc_cnt`==0: load a terminator word with data 0, keep 0, last=1.
- Then clear `finish_pend` and `acc_cnt`, and go FLUSH → RUN.
- `byte_count` and `checksum` hold after flush. Both clear on the first capture after a completed flush, and that capture's byte counts as 1 / its value.

**Output handshake**
- `word_valid` stays high until `word_ready`. Data, keep and last are stable while valid and not ready.
- When `word_ready` and a new load fall on the same edge, the register reloads and valid stays 1.

## Timing
- Reset value of every output is 0; state is RUN.
- Reset mid-word discards the accumulator and any in-flight byte. An in-flight FIFO read is then lost, which is acceptable because the reader is reset together with this block.
- Pop-to-capture latency is 1 cycle.
- Latency from the last byte's capture to `word_valid` is 1 edge.
- Sustained throughput is WORD_BYTES bytes per WORD_BYTES+1 cycles, because the pop for the next word waits for the capture of the completing byte.
- Flush word appears 1 cycle after the FLUSH entry, if the output register is free.
- `read_finish` arriving with bytes still in the FIFO: all of those bytes are drained and packed before the flush.

## Configuration
- Macro: `FLASH_PACK_CSUM_EN`.
- Defined: the checksum accumulates as described.
- Undefined: the checksum register and adder are removed, and the `checksum` port is tied to 32'h0. The port list does not change.

## Structure
- Package `flash_pack_pkg`:
  - state enum (RUN, FLUSH);
  - `FP_MAX_WORD_BYTES`=4;
  - the checksum width constant.
- One sub-module, `flash_pack_csum`: the checksum accumulator, with clear, enable, byte in and sum out. It is instantiated only under `FLASH_PACK_CSUM_EN`.

## Test plan
- **Basic packing**
  - Stimulus: bytes 11,22,33,44 with defaults.
  - Required: one word `0x44332211`, keep `0xF`, last=0, `byte_count`=4.
- **Partial final word**
  - Stimulus: bytes 11..66 (6 bytes), then `read_finish`.
  - Required: word 1 is `0x44332211`; word 2 is `0x00006655` with keep `0x3` and last=1.
- **Back-pressure**
  - Stimulus: `word_ready`=0 for 30 cycles, 12 bytes queued.
  - Required: exactly 8 pops (output register plus full accumulator), then `fifo_read_req` stays low.
  - On release, words arrive in order with no byte lost.
- **Word-aligned finish**
  - Stimulus: `read_finish` after exactly 8 bytes.
  - Required: two full words, then a terminator with keep `0x0`, data 0, last=1.
- **Checksum**
  - Stimulus: bytes FF,FF,FF,FF with the macro defined.
  - Required: `checksum`=`0x3FC`. Without the macro, `checksum`=0.
- **Reset mid-word**
  - Stimulus: assert reset after 2 bytes captured.
  - Required: all outputs 0. After release, the next 4 bytes form a clean word with `byte_count`=4.
